// File: rtl/zigzag_encoder.sv
// Zigzag run-length encoder: collects 8x8 coefficient blocks column by column into a
// ping-pong buffer pair and emits (run, value) pairs in JPEG zigzag scan order.

// One lane of both block buffers: column k of the lane lives at mem_q[buf][k].
module zigzag_encoder_lane #(
    parameter int VEC_W = 12
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic             wr_buf_i,
    input  logic [2:0]       wr_col_i,
    input  logic [VEC_W-1:0] wr_data_i,
    input  logic             rd_buf_i,
    input  logic [2:0]       rd_col_i,
    output logic [VEC_W-1:0] rd_data_o
);
    logic [VEC_W-1:0] mem_q [2][8];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_buf_i][wr_col_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_buf_i][rd_col_i];
endmodule

module zigzag_encoder #(
    parameter int VEC_W = 12
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [8*VEC_W-1:0] column_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [VEC_W-1:0]   value_out,
    output logic [5:0]         run_out,
    output logic               valid_out,
    output logic               last_out
);
    localparam int NUM_LANES = 8;
    localparam int STAGES    = 3;

    localparam logic [5:0] ZZ_TBL [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {S_IDLE, S_SCAN} scan_state_e;

    logic [NUM_LANES-1:0][VEC_W-1:0] col_lanes;
    logic [NUM_LANES-1:0][VEC_W-1:0] lane_rd;

    // Fill side
    logic       fill_sel_q, fill_sel_d;
    logic [2:0] col_cnt_q, col_cnt_d;
    logic [1:0] full_q, full_d;
    logic       accept;

    // Scan side
    scan_state_e state_q, state_d;
    logic        scan_sel_q, scan_sel_d;
    logic [5:0]  scan_idx_q, scan_idx_d;
    logic        scan_end;
    logic [5:0]  rd_raster;
    logic [VEC_W-1:0] coef_rd;

    // Pipeline
    logic [STAGES:1]  vld_pipe_q;
    logic [VEC_W-1:0] p1_coef_q;
    logic [5:0]       p1_idx_q;
    logic [5:0]       zrun_q, zrun_d;
    logic [5:0]       zeros;
    logic             p1_nz, p1_term;
    logic             emit2_q, last2_q, emit3_q, last3_q;
    logic [5:0]       run2_q, run3_q;
    logic [VEC_W-1:0] val2_q, val3_q;

    assign col_lanes = column_in;
    assign ready_out = ~&full_q;
    assign accept    = valid_in && ready_out;
    assign scan_end  = (state_q == S_SCAN) && (scan_idx_q == 6'd63);
    assign rd_raster = ZZ_TBL[scan_idx_q];

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        zigzag_encoder_lane #(.VEC_W(VEC_W)) u_lane (
            .clk_i     (clk_in),
            .wr_en_i   (accept),
            .wr_buf_i  (fill_sel_q),
            .wr_col_i  (col_cnt_q),
            .wr_data_i (col_lanes[j]),
            .rd_buf_i  (scan_sel_q),
            .rd_col_i  (rd_raster[5:3]),
            .rd_data_o (lane_rd[j])
        );
    end

    assign coef_rd = lane_rd[rd_raster[2:0]];

    // Scan always follows fill order, so scan_sel simply toggles after every block;
    // a buffer completing on the same edge a scan ends is picked up with no gap.
    always_comb begin
        full_d     = full_q;
        fill_sel_d = fill_sel_q;
        col_cnt_d  = col_cnt_q;
        if (accept) begin
            col_cnt_d = col_cnt_q + 3'd1;
            if (col_cnt_q == 3'd7) begin
                full_d[fill_sel_q] = 1'b1;
                fill_sel_d         = ~fill_sel_q;
            end
        end
        if (scan_end) begin
            full_d[scan_sel_q] = 1'b0;
        end
    end

    always_comb begin
        scan_sel_d = scan_end ? ~scan_sel_q : scan_sel_q;
        state_d    = full_d[scan_sel_d] ? S_SCAN : S_IDLE;
        scan_idx_d = 6'd0;
        if (state_q == S_SCAN && !scan_end) begin
            scan_idx_d = scan_idx_q + 6'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fill_sel_q <= 1'b0;
            col_cnt_q  <= 3'd0;
            full_q     <= 2'b00;
            state_q    <= S_IDLE;
            scan_sel_q <= 1'b0;
            scan_idx_q <= 6'd0;
        end else begin
            fill_sel_q <= fill_sel_d;
            col_cnt_q  <= col_cnt_d;
            full_q     <= full_d;
            state_q    <= state_d;
            scan_sel_q <= scan_sel_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    // Run of zeros restarts at scan index 0, so back-to-back blocks need no flush.
    assign zeros   = (p1_idx_q == 6'd0) ? 6'd0 : zrun_q;
    assign p1_nz   = (p1_coef_q != '0);
    assign p1_term = (p1_idx_q == 6'd63);

    always_comb begin
        zrun_d = zrun_q;
        if (vld_pipe_q[1]) begin
            zrun_d = p1_nz ? 6'd0 : zeros + 6'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_pipe_q <= '0;
            zrun_q     <= 6'd0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], (state_q == S_SCAN)};
            zrun_q     <= zrun_d;
        end
    end

    always_ff @(posedge clk_in) begin
        p1_coef_q <= coef_rd;
        p1_idx_q  <= scan_idx_q;
        emit2_q   <= p1_nz || p1_term;
        last2_q   <= p1_term;
        run2_q    <= zeros;
        val2_q    <= p1_coef_q;
        emit3_q   <= emit2_q;
        last3_q   <= last2_q;
        run3_q    <= run2_q;
        val3_q    <= val2_q;
    end

    assign valid_out = vld_pipe_q[STAGES] && emit3_q;
    assign run_out   = valid_out ? run3_q : 6'd0;
    assign value_out = valid_out ? val3_q : '0;
    assign last_out  = valid_out && last3_q;

    a_fill_free: assert property (@(posedge clk_in) disable iff (rst_in)
        accept |-> !full_q[fill_sel_q]);
    a_scan_owned: assert property (@(posedge clk_in) disable iff (rst_in)
        (state_q == S_SCAN) |-> full_q[scan_sel_q]);
endmodule

// File: tb/tb_zigzag_encoder.sv
// Randomized scoreboard bench for zigzag_encoder with a diagonal-walk zigzag model.
module tb_zigzag_encoder;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [95:0] column_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [11:0] value_out;
    logic [5:0]  run_out;
    logic        valid_out;
    logic        last_out;

    zigzag_encoder dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .column_in (column_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .value_out (value_out),
        .run_out   (run_out),
        .valid_out (valid_out),
        .last_out  (last_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int run;
        int val;
        bit last;
        int cyc;
    } pair_t;

    pair_t        exp_q[$];
    logic [767:0] blk_q[$];
    int           zz [64];
    int           tests = 0;
    int           fails = 0;
    int           edges = 0;
    bit           mon_en = 0;
    int           last_S = -1000;
    int           first_E = 0;
    int           last_E = 0;

    always @(posedge clk_in) edges <= edges + 1;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, edges);
        end
    endtask

    // Zigzag order from the diagonal walk: even diagonals run bottom-left to top-right.
    task automatic build_zz();
        int s = 0;
        for (int d = 0; d < 15; d++) begin
            int lo = (d > 7) ? d - 7 : 0;
            int hi = (d < 7) ? d : 7;
            for (int i = 0; i <= hi - lo; i++) begin
                int row = (d % 2 == 0) ? hi - i : lo + i;
                zz[s] = 8 * row + (d - row);
                s++;
            end
        end
    endtask

    function automatic int coef(input logic [767:0] b, input int r);
        logic signed [11:0] c;
        c = b[12*r +: 12];
        return c;
    endfunction

    function automatic logic [767:0] put(input logic [767:0] b, input int r, input int v);
        logic [767:0] o;
        o = b;
        o[12*r +: 12] = v[11:0];
        return o;
    endfunction

    task automatic push_expected(input logic [767:0] b, input int S);
        pair_t e;
        int    p = 0;
        for (int s = 0; s < 64; s++) begin
            int v = coef(b, zz[s]);
            if (v != 0) begin
                e.run = s - p; e.val = v; e.last = (s == 63); e.cyc = S + s + 3;
                exp_q.push_back(e);
                p = s + 1;
            end
        end
        if (coef(b, zz[63]) == 0) begin
            e.run = 63 - p; e.val = 0; e.last = 1; e.cyc = S + 66;
            exp_q.push_back(e);
        end
        blk_q.push_back(b);
    endtask

    // Called at posedge+1; returns at posedge+1 of the period after the 8th acceptance.
    task automatic send_block(input logic [767:0] b, input int gap_max);
        for (int k = 0; k < 8; k++) begin
            int wait_cnt = 0;
            bit acc = 0;
            repeat ($urandom_range(gap_max, 0)) begin
                valid_in  = 1'b0;
                column_in = {$urandom(), $urandom(), $urandom()};
                @(posedge clk_in); #1;
            end
            valid_in  = 1'b1;
            column_in = b[96*k +: 96];
            while (!acc && wait_cnt < 300) begin
                @(negedge clk_in);
                acc = ready_out;
                @(posedge clk_in); #1;
                wait_cnt++;
            end
            if (!acc) begin
                tests++; fails++;
                $display("FAIL accept_timeout: column %0d not accepted, ready_out %0b, required 1", k, ready_out);
            end
            if (k == 0) first_E = edges;
            valid_in = 1'b0;
        end
        last_E = edges;
        last_S = (last_E > last_S + 64) ? last_E : last_S + 64;
        push_expected(b, last_S);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d pairs outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst_in   = 1'b1;
        valid_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        last_S = -1000;
    endtask

    function automatic logic [767:0] rand_block(input int density);
        logic [767:0] b = '0;
        for (int r = 0; r < 64; r++) begin
            if ($urandom_range(15, 0) < density) b = put(b, r, $urandom_range(4095, 1));
        end
        return b;
    endfunction

    // Monitor: scoreboard compare plus decode back to raster for round-trip checking.
    int dec [64];
    int pos = 0;
    always @(negedge clk_in) begin : mon
        pair_t        e;
        logic [767:0] rec;
        logic [767:0] ref_blk;
        int           v;
        if (mon_en) begin
            if (valid_out) begin
                v = $signed(value_out);
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_pair: got run %0d value %0d at cycle %0d, required none",
                             run_out, v, edges);
                end else begin
                    e = exp_q.pop_front();
                    check("pair_run", run_out, e.run);
                    check("pair_value", v, e.val);
                    check("pair_last", last_out, e.last);
                    check("pair_cycle", edges, e.cyc);
                end
                pos = pos + run_out;
                if (pos < 64) dec[pos] = v;
                pos++;
                if (last_out) begin
                    check("run_sum", pos, 64);
                    rec = '0;
                    for (int s = 0; s < 64; s++) rec = put(rec, zz[s], dec[s]);
                    tests++;
                    if (blk_q.size() == 0) begin
                        fails++;
                        $display("FAIL roundtrip: block decoded with no block outstanding");
                    end else begin
                        ref_blk = blk_q.pop_front();
                        if (rec !== ref_blk) begin
                            fails++;
                            $display("FAIL roundtrip: got %h, expected %h", rec, ref_blk);
                        end
                    end
                    pos = 0;
                    for (int s = 0; s < 64; s++) dec[s] = 0;
                end
            end else begin
                check("idle_outputs_zero", {run_out, value_out, last_out}, 0);
            end
        end
        if (rst_in) begin
            exp_q.delete();
            blk_q.delete();
            pos = 0;
            for (int s = 0; s < 64; s++) dec[s] = 0;
        end
    end

    initial begin
        logic [767:0] b;
        logic [767:0] b40;
        int S1;
        int S;
        int cnt;
        int r;

        build_zz();
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        mon_en = 1'b1;
        @(negedge clk_in);
        check("reset_ready", ready_out, 1);
        check("reset_valid", valid_out, 0);
        @(posedge clk_in); #1;

        // All-zero block: single terminating pair
        send_block('0, 0);
        drain();

        // DC and last coefficient only
        b = put('0, 0, 5);
        b = put(b, 63, -3);
        send_block(b, 1);
        drain();

        // Two leading nonzeros then terminator
        b = put('0, 1, 7);
        b = put(b, 8, -1);
        send_block(b, 0);
        drain();

        // Three blocks back to back: backpressure and contiguous scans
        send_block(rand_block(8), 0);
        S1 = last_S;
        send_block(rand_block(3), 0);
        @(negedge clk_in);
        check("ready_low_after_block2", ready_out, 0);
        @(posedge clk_in); #1;
        send_block(rand_block(14), 0);
        check("block3_accept_edge", first_E, S1 + 65);
        drain();

        // Random blocks with random input gaps and densities
        for (int n = 0; n < 12; n++) begin
            send_block(rand_block($urandom_range(16, 0)), 2);
        end
        drain();

        // Reset in the middle of a scan, then the same block from clean state
        b40 = '0;
        cnt = 0;
        while (cnt < 40) begin
            r = $urandom_range(63, 0);
            if (coef(b40, r) == 0) begin
                b40 = put(b40, r, $urandom_range(4095, 1));
                cnt++;
            end
        end
        send_block(b40, 0);
        S = last_S;
        while (edges < S + 30) begin
            @(posedge clk_in); #1;
        end
        do_reset();
        @(negedge clk_in);
        check("midscan_reset_valid", valid_out, 0);
        check("midscan_reset_ready", ready_out, 1);
        repeat (10) @(posedge clk_in);
        #1;
        send_block(b40, 0);
        drain();

        repeat (10) @(posedge clk_in);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/zigzag_encoder.md
ZIGZAG_ENCODER -- requirements
Module: zigzag_encoder

Interface
REQ-001 clk_in  input  1  sole clock; all logic on rising edge.
REQ-002 rst_in  input  1  synchronous, active-high reset.
REQ-003 column_in  input  96  one 8-coefficient column; lane j = bits [12j+11:12j], signed 12-bit two's complement.
REQ-004 valid_in  input  1  column_in valid this cycle.
REQ-005 ready_out  output  1  encoder can accept a column this cycle.
REQ-006 value_out  output  12  signed coefficient of emitted (run, value) pair.
REQ-007 run_out  output  6  count of zero coefficients skipped before value_out in scan order.
REQ-008 valid_out  output  1  pair on run_out/value_out valid this cycle.
REQ-009 last_out  output  1  high with the final pair of each block.

Function
REQ-010 Column accepted only on cycle with valid_in && ready_out; valid_in while ready_out low is ignored, with no state change.
REQ-011 Eight accepted columns form one block; column k (0..7, arrival order), lane j SHALL be raster index r = 8k+j.
REQ-012 Two block buffers, ping-pong: one filling, one scanning; fill target alternates after every 8th column.
REQ-013 ready_out SHALL be 0 only when both buffers hold complete, unscanned or in-scan blocks; otherwise 1.
REQ-014 Scan of a block starts the cycle after its 8th column is accepted if scanner idle, else the cycle after the current scan ends; no idle gap between back-to-back blocks.
REQ-015 Scanner examines exactly one coefficient per cycle, scan index s = 0..63, raster index = standard JPEG zigzag table (0,1,8,16,9,2,3,10,17,24,...,55,62,63); a scan occupies 64 cycles.
REQ-016 Each nonzero coefficient at scan index s SHALL emit one pair: run = zeros since previous emitted pair (or block start), value = coefficient.
REQ-017 DC (s=0) follows the same rule; a zero DC is a skipped zero.
REQ-018 If scan index 63 is zero, a terminating pair SHALL be emitted: run = 63 - p, value = 0, where p = scan index following last emitted nonzero (0 if none).
REQ-019 Invariant: per block, sum of (run+1) over all pairs = 64 exactly.
REQ-020 last_out = 1 on the pair whose cumulative sum reaches 64, else 0.
REQ-021 Latency: pair for scan index s appears with valid_out = 1 exactly 3 cycles after scan cycle s.
REQ-022 At most one pair per cycle; pairs never reordered across blocks.
REQ-023 When valid_out = 0, run_out, value_out, last_out SHALL be 0.
REQ-024 Scan buffer is released on the cycle after scan index 63 is examined; a column arriving that same cycle is accepted if ready_out was 1.
REQ-025 Buffer contents are fully overwritten by each new block; no stale lanes leak into later blocks.

Reset
REQ-026 While rst_in high: valid_out = 0, last_out = 0, run_out = 0, value_out = 0, ready_out = 1 from the following cycle.
REQ-027 Reset mid-fill or mid-scan discards partial columns, both buffers, and in-flight pairs; the next accepted column is column 0 of a new block.

Verification
REQ-028 All-zero block, 8 consecutive columns -> exactly one pair (run 63, value 0, last 1), 66 cycles after first scan cycle.
REQ-029 Block with raster[0]=5, raster[63]=-3, else 0 -> (0,5) at scan+3, (62,-3,last) at scan+66.
REQ-030 Raster[1]=7, raster[8]=-1, else 0 -> (1,7), (0,-1), (60,0,last); scan indices 1 and 2, run sum 64.
REQ-031 Three blocks, columns presented every cycle -> ready_out drops after block 2 completes, returns when block 1 scan ends; blocks 1-3 pairs contiguous with 64-cycle spacing and correct order.
REQ-032 Reset asserted at scan index 30 of a block with 40 nonzeros -> valid_out 0 next cycle, no further pairs; new block afterward encodes identically to a fresh-from-reset run.
REQ-033 Round trip: random blocks through encoder then the existing zigzag decoder -> decoded columns equal input columns bit-exactly.
